sine_dac: RTL and testbench
===========================

SINE_DAC -- requirements
Module: sine_dac

Interface
REQ-001 Parameter WIDTH, default 12, sets the sample code width in bits.
REQ-002 Parameter ADDR, default 8, sets the LUT address width; the table has 2^ADDR points per period.
REQ-003 Parameter DIV, default 10, sets the clock cycles per sample step.
REQ-004 Parameter VREF, real, default 3.3, sets the full-scale analog output in volts.
REQ-005 Port clk, input, 1 bit: the single clock, 100 MHz nominal; all logic uses its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 Port en, input, 1 bit: generator enable.
REQ-008 Port sine_code, output, WIDTH bits: registered unsigned sample code.
REQ-009 Port A_Sine_data, output, real: analog DAC model output in volts.

Function
REQ-010 The module SHALL hold a prescaler counter 0..DIV-1 and a phase index 0..2^ADDR-1.
REQ-011 On a clk edge with en=1 and prescaler<DIV-1, the prescaler SHALL increment; the index and code SHALL hold.
REQ-012 On a clk edge with en=1 and prescaler=DIV-1, the prescaler SHALL clear and the index SHALL increment modulo 2^ADDR.
REQ-013 On that same edge, sine_code SHALL load LUT(new index); update latency is 0 cycles after the step.
REQ-014 LUT(k) SHALL equal round(2^(WIDTH-1) + (2^(WIDTH-1)-1)*sin(2*pi*k/2^ADDR)); with the defaults the range is 1..4095, LUT(0)=2048, LUT(64)=4095, LUT(192)=1.
REQ-015 With en=0, the prescaler, index and sine_code SHALL freeze; the next en=1 edge SHALL resume from the frozen state with no skip and no restart.
REQ-016 The index SHALL wrap from 2^ADDR-1 to 0 with no glitch; LUT(0) follows LUT(255).
REQ-017 A_Sine_data SHALL equal VREF*sine_code/(2^WIDTH-1), updated in the same time step as sine_code, with no added clock latency.
REQ-018 The sample period SHALL be DIV*2^ADDR clock cycles; the defaults give 2560 cycles, which is 25.6 us at 100 MHz.

Reset
REQ-019 While rst=1, regardless of clk or en: prescaler=0, index=0, sine_code=2^(WIDTH-1), which is 2048 with the defaults.
REQ-020 Under the same reset conditions, A_Sine_data SHALL read approximately 1.6504 V with the defaults.
REQ-021 Reset asserted mid-operation SHALL take effect immediately, without waiting for a clock edge.
REQ-022 After reset deasserts, the first step SHALL occur on the DIV-th enabled rising edge.

Configuration
REQ-023 With macro SINE_DAC_QUARTER_LUT_EN defined, the LUT SHALL store only quarter-wave points 0..2^(ADDR-2) and rebuild the other quadrants by index mirroring and code inversion about midscale.
REQ-024 Without SINE_DAC_QUARTER_LUT_EN, a full 2^ADDR-entry table SHALL be used.
REQ-025 Both builds SHALL produce bit-identical sine_code sequences.

Structure
REQ-026 Package sine_dac_pkg SHALL hold the default WIDTH, ADDR, DIV and VREF constants, the MIDSCALE constant, and the code/index typedefs.
REQ-027 The table SHALL live in one sub-module, sine_lut, a combinational index-to-code lookup that includes the quarter-wave logic when enabled.
REQ-028 Benches SHALL use a separate non-synthesizable clock source, clock_gen, with output clk, 10 ns period, 50% duty, starting low.

Verification
REQ-029 Reset check: rst=1 with en=1 -> sine_code=2048 and A_Sine_data=1.650 V within 1 mV, with no clk edge required.
REQ-030 Stepping check: en=1 after reset -> code changes every 10 cycles; after 64 steps (640 cycles) code=4095 and A=3.300 V; after 192 steps code=1.
REQ-031 Wrap check: after 256 steps (25.6 us) the index is 0 and code=2048; the next step gives LUT(1)=2098.
REQ-032 Hold check: en=0 at 70 us after reset (index 188), held 30 us -> code and A constant; en=1 -> the next step gives LUT(189) after 10 cycles.
REQ-033 Reset check mid-sweep: rst pulse at index 100 -> code=2048 immediately; after release the sweep restarts at LUT(1).
REQ-034 Configuration check: run a full period with and without SINE_DAC_QUARTER_LUT_EN -> all 256 codes match.

Source files
------------

// File: rtl/sine_dac_pkg.sv
// -----------------------------------------------------------------------------
// sine_dac_pkg
// Shared constants, types and table-building helpers for the sine DAC model.
//   DEFAULT_WIDTH / DEFAULT_ADDR / DEFAULT_DIV / DEFAULT_VREF : default params
//   MIDSCALE                                                 : 2^(WIDTH-1)
//   code_t / index_t                                         : default-width types
//   sine_point(k, width, addr) : elaboration-time LUT value for phase index k
// The sine is evaluated with integer fixed-point arithmetic (Q.48) so the
// table is a pure constant on every tool without relying on real-valued
// system functions during elaboration.
// -----------------------------------------------------------------------------
package sine_dac_pkg;

    localparam int  DEFAULT_WIDTH = 12;
    localparam int  DEFAULT_ADDR  = 8;
    localparam int  DEFAULT_DIV   = 10;
    localparam real DEFAULT_VREF  = 3.3;
    localparam int  MIDSCALE      = 1 << (DEFAULT_WIDTH - 1);

    typedef logic [DEFAULT_WIDTH-1:0] code_t;
    typedef logic [DEFAULT_ADDR-1:0]  index_t;

    // Fixed-point fraction bits and pi in that format (hex expansion of pi).
    localparam int          FRAC  = 48;
    localparam logic [51:0] PI_FX = 52'h3243F6A8885A3;

    // round((2^(width-1)-1) * sin(2*pi*k/2^addr)) for 0 <= k <= 2^(addr-2).
    // Angle stays within [0, pi/2], so every Taylor partial sum is positive
    // and plain unsigned arithmetic is safe.
    function automatic int unsigned quarter_amp(input int unsigned k,
                                                input int unsigned width,
                                                input int unsigned addr);
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] acc;
        logic [127:0] prod;
        x    = ({76'd0, PI_FX} * 128'(2 * k)) >> addr;
        x2   = (x * x) >> FRAC;
        term = x;
        acc  = x;
        for (int n = 1; n <= 12; n++) begin
            term = ((term * x2) >> FRAC) / 128'((2 * n) * (2 * n + 1));
            if ((n % 2) == 1)
                acc = acc - term;
            else
                acc = acc + term;
        end
        prod = acc * 128'((1 << (width - 1)) - 1) + (128'd1 << (FRAC - 1));
        return 32'(prod >> FRAC);
    endfunction

    // Full-period LUT value, built from the first quadrant by symmetry.
    function automatic int unsigned sine_point(input int unsigned k,
                                               input int unsigned width,
                                               input int unsigned addr);
        int unsigned npts;
        int unsigned qtr;
        int unsigned mid;
        int unsigned kk;
        npts = 1 << addr;
        qtr  = npts >> 2;
        mid  = 1 << (width - 1);
        kk   = k % npts;
        if (kk <= qtr)
            return mid + quarter_amp(kk, width, addr);
        else if (kk < 2 * qtr)
            return mid + quarter_amp(2 * qtr - kk, width, addr);
        else if (kk <= 3 * qtr)
            return mid - quarter_amp(kk - 2 * qtr, width, addr);
        else
            return mid - quarter_amp(npts - kk, width, addr);
    endfunction

endpackage

// File: rtl/sine_lut.sv
// -----------------------------------------------------------------------------
// sine_lut
// Combinational phase-index to sample-code lookup.
//   idx_i  [ADDR-1:0]  : phase index
//   code_o [WIDTH-1:0] : unsigned sine code for idx_i
// Build option: define SINE_DAC_QUARTER_LUT_EN to store only the quarter wave
// (points 0..2^(ADDR-2)) and rebuild the other quadrants by index mirroring
// and inversion about midscale. Otherwise the full 2^ADDR-point table is used.
// Both builds yield identical codes.
// -----------------------------------------------------------------------------
module sine_lut
    import sine_dac_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int ADDR  = DEFAULT_ADDR
) (
    input  logic [ADDR-1:0]  idx_i,
    output logic [WIDTH-1:0] code_o
);

`ifdef SINE_DAC_QUARTER_LUT_EN
    localparam int QN = 1 << (ADDR - 2);

    logic [WIDTH-1:0] quarter_rom [QN+1];

    generate
        for (genvar gi = 0; gi <= QN; gi++) begin : g_rom
            localparam int unsigned VAL = sine_point(gi, WIDTH, ADDR);
            assign quarter_rom[gi] = VAL[WIDTH-1:0];
        end
    endgenerate

    logic [1:0]      quad;
    logic [ADDR-3:0] low;
    logic [ADDR-2:0] q_idx;
    logic [WIDTH-1:0] q_code;

    always_comb begin
        quad   = idx_i[ADDR-1:ADDR-2];
        low    = idx_i[ADDR-3:0];
        // Odd quadrants run the quarter table backwards; low=0 maps to the peak.
        q_idx  = quad[0] ? ((ADDR-1)'(QN) - {1'b0, low}) : {1'b0, low};
        q_code = quarter_rom[q_idx];
        // Lower half-wave: 2*MID - q, which modulo 2^WIDTH is simply -q
        // (and keeps MID at MID for the zero crossing).
        code_o = quad[1] ? (WIDTH'(0) - q_code) : q_code;
    end
`else
    localparam int NPTS = 1 << ADDR;

    logic [WIDTH-1:0] full_rom [NPTS];

    generate
        for (genvar gi = 0; gi < NPTS; gi++) begin : g_rom
            localparam int unsigned VAL = sine_point(gi, WIDTH, ADDR);
            assign full_rom[gi] = VAL[WIDTH-1:0];
        end
    endgenerate

    assign code_o = full_rom[idx_i];
`endif

endmodule

// File: rtl/sine_dac.sv
// -----------------------------------------------------------------------------
// sine_dac
// Table-driven sine generator with an ideal DAC output model.
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   en          : enable; when low, all state freezes
//   sine_code   : registered unsigned sample code [WIDTH-1:0]
//   A_Sine_data : analog model, VREF*sine_code/(2^WIDTH-1) volts
// A prescaler counts DIV enabled cycles per phase step; on the step edge the
// phase index advances (mod 2^ADDR) and the code loads LUT(new index).
// Build option SINE_DAC_QUARTER_LUT_EN selects the quarter-wave table in
// sine_lut; behaviour is identical either way.
// -----------------------------------------------------------------------------
module sine_dac
    import sine_dac_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    parameter int  ADDR  = DEFAULT_ADDR,
    parameter int  DIV   = DEFAULT_DIV,
    parameter real VREF  = DEFAULT_VREF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] sine_code,
    output real              A_Sine_data
);

    localparam int               PW            = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESCALE_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] CODE_MID      = WIDTH'(1 << (WIDTH - 1));
    localparam real              FULL_SCALE    = (2.0 ** WIDTH) - 1.0;

    logic [PW-1:0]    prescale_q, prescale_d;
    logic [ADDR-1:0]  index_q, index_d;
    logic [ADDR-1:0]  index_next;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] lut_code;

    // The table always looks one index ahead so the code can load in the
    // same edge that advances the index.
    sine_lut #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR)
    ) u_lut (
        .idx_i  (index_next),
        .code_o (lut_code)
    );

    always_comb begin
        index_next = index_q + ADDR'(1);
        prescale_d = prescale_q;
        index_d    = index_q;
        code_d     = code_q;
        if (en) begin
            if (prescale_q == PRESCALE_LAST) begin
                prescale_d = '0;
                index_d    = index_next;
                code_d     = lut_code;
            end else begin
                prescale_d = prescale_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale_q <= '0;
            index_q    <= '0;
            code_q     <= CODE_MID;
        end else begin
            prescale_q <= prescale_d;
            index_q    <= index_d;
            code_q     <= code_d;
        end
    end

    assign sine_code   = code_q;
    assign A_Sine_data = VREF * real'(code_q) / FULL_SCALE;

endmodule

// File: tb/tb_sine_dac.sv
// -----------------------------------------------------------------------------
// tb_sine_dac
// Directed bench for sine_dac with default parameters. Expected codes come
// from a real-valued sine reference and are queued when a step is scheduled,
// then popped and compared once the step edge has passed.
// -----------------------------------------------------------------------------
module tb_sine_dac;

    localparam int  WIDTH = 12;
    localparam int  ADDR  = 8;
    localparam int  DIV   = 10;
    localparam real VREF  = 3.3;
    localparam int  NPTS  = 1 << ADDR;
    localparam real FS    = 4095.0;
    localparam real PI    = 3.14159265358979323846;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] sine_code;
    real              A_Sine_data;

    int checks;
    int errors;
    int model_idx;
    int prev_code;
    int exp_q[$];

    sine_dac #(
        .WIDTH (WIDTH),
        .ADDR  (ADDR),
        .DIV   (DIV),
        .VREF  (VREF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sine_code   (sine_code),
        .A_Sine_data (A_Sine_data)
    );

    // 10 ns period, 50% duty, starts low.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_code(input int k);
        real v;
        v = 2048.0 + 2047.0 * $sin(2.0 * PI * real'(k) / real'(NPTS));
        return $rtoi($floor(v + 0.5));
    endfunction

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_real(input string tag, input real obs, input real exp);
        bit ok;
        ok = ((obs - exp) < 0.001) && ((exp - obs) < 0.001);
        checks++;
        assert (ok === 1'b1)
        else begin
            errors++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
        end
    endtask

    // Schedule n steps; each must land exactly on the DIV-th enabled edge.
    task automatic do_steps(input int n);
        int got;
        for (int s = 0; s < n; s++) begin
            model_idx = (model_idx + 1) % NPTS;
            exp_q.push_back(ref_code(model_idx));
            repeat (DIV - 1) @(posedge clk);
            #1;
            check_int("pre_step_hold", int'(sine_code), prev_code);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            check_int("step_code", int'(sine_code), got);
            check_real("step_analog", A_Sine_data, VREF * real'(got) / FS);
            prev_code = got;
            $display("step idx=%0d code=%0d exp=%0d", model_idx, sine_code, got);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_idx = 0;
        prev_code = 2048;
        en        = 1'b1;
        rst       = 1'b0;

        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_int("reset_code", int'(sine_code), 2048);
        check_real("reset_analog", A_Sine_data, 1.6504);
        $display("reset code=%0d A=%f", sine_code, A_Sine_data);

        repeat (3) @(posedge clk);
        #1;
        check_int("reset_hold_code", int'(sine_code), 2048);
        rst = 1'b0;

        // Sweep to the peak, the trough and the wrap point.
        do_steps(64);
        check_int("peak_code", int'(sine_code), 4095);
        check_real("peak_analog", A_Sine_data, 3.3);
        do_steps(128);
        check_int("trough_code", int'(sine_code), 1);
        do_steps(64);
        check_int("wrap_code", int'(sine_code), 2048);
        do_steps(1);
        check_int("after_wrap_code", int'(sine_code), 2098);

        // Advance to index 188, then freeze mid-prescale.
        do_steps(187);
        check_int("pre_freeze_idx188", int'(sine_code), ref_code(188));
        repeat (4) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (1500) @(posedge clk);
        #1;
        check_int("freeze_mid_code", int'(sine_code), ref_code(188));
        repeat (1500) @(posedge clk);
        #1;
        check_int("freeze_end_code", int'(sine_code), ref_code(188));
        check_real("freeze_end_analog", A_Sine_data, VREF * real'(ref_code(188)) / FS);
        $display("freeze held code=%0d", sine_code);

        // Resume: 4 counts were already taken, so 6 more edges to the step.
        en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_int("resume_no_skip", int'(sine_code), ref_code(188));
        @(posedge clk);
        #1;
        check_int("resume_step_code", int'(sine_code), ref_code(189));
        model_idx = 189;
        prev_code = ref_code(189);
        $display("resume idx=189 code=%0d", sine_code);

        // Mid-sweep reset at index 100, asserted between clock edges.
        do_steps(167);
        check_int("pre_reset_idx100", int'(sine_code), ref_code(100));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_int("midsweep_reset_code", int'(sine_code), 2048);
        check_real("midsweep_reset_analog", A_Sine_data, 1.6504);
        $display("midsweep reset code=%0d", sine_code);
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b0;
        model_idx = 0;
        prev_code = 2048;
        do_steps(1);
        check_int("restart_code", int'(sine_code), 2098);
        do_steps(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
